seg_decoder: RTL and testbench

SEG_DECODER -- requirements
Module: seg_decoder

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg7_lut.sv | 36 +++
 rtl/seg_decoder.sv | 119 +++++++++++
 tb/tb_seg_decoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment decoder: digit patterns (bit0=a .. bit6=g)
// and the settle/lock state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : seg_pkg

// File: rtl/seg7_lut.sv
// Pure combinational lookup from a 7-bit segment pattern to its digit value,
// with flags telling whether the pattern is a legal digit or all-dark.
module seg7_lut
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] value_o,
  output logic       is_digit_o,
  output logic       is_blank_o
);

  // Anything not listed is neither a digit nor blank; value is then don't-care (0).
  always_comb begin
    value_o    = 4'd0;
    is_digit_o = 1'b1;
    is_blank_o = 1'b0;
    case (pattern_i)
      SEG_0:     value_o = 4'd0;
      SEG_1:     value_o = 4'd1;
      SEG_2:     value_o = 4'd2;
      SEG_3:     value_o = 4'd3;
      SEG_4:     value_o = 4'd4;
      SEG_5:     value_o = 4'd5;
      SEG_6:     value_o = 4'd6;
      SEG_7:     value_o = 4'd7;
      SEG_8:     value_o = 4'd8;
      SEG_9:     value_o = 4'd9;
      SEG_BLANK: begin
        is_digit_o = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   is_digit_o = 1'b0;
    endcase
  end

endmodule : seg7_lut

// File: rtl/seg_decoder.sv
// Debounced seven-segment decoder: a pattern must be held for STABLE_CYCLES
// consecutive matching samples before it is decoded and reported.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [7:0] seg_in,
  output logic [3:0] digit,
  output logic       dp,
  output logic       digit_valid,
  output logic       blank,
  output logic       invalid,
  output logic       new_digit,
  output logic [7:0] accept_count
);

  localparam logic [3:0] CNT_SAT = 4'(STABLE_CYCLES);
  localparam logic [3:0] LOCK_AT = 4'(STABLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       dp_q, dp_d;
  logic       valid_q, valid_d;
  logic       blank_q, blank_d;
  logic       invalid_q, invalid_d;
  logic       newDigit_q, newDigit_d;
  logic [7:0] acceptCount_q, acceptCount_d;

  logic       inputStable;
  logic [3:0] lutValue;
  logic       lutDigit;
  logic       lutBlank;

  assign inputStable = (seg_in == s_q);

  // Decoding s_q rather than seg_in is safe: on an accepting edge the two are equal.
  seg7_lut u_lut (
    .pattern_i  (s_q[6:0]),
    .value_o    (lutValue),
    .is_digit_o (lutDigit),
    .is_blank_o (lutBlank)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q       <= SETTLE;
      s_q           <= 8'h00;
      cnt_q         <= 4'd0;
      digit_q       <= 4'd0;
      dp_q          <= 1'b0;
      valid_q       <= 1'b0;
      blank_q       <= 1'b0;
      invalid_q     <= 1'b0;
      newDigit_q    <= 1'b0;
      acceptCount_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      s_q           <= seg_in;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      dp_q          <= dp_d;
      valid_q       <= valid_d;
      blank_q       <= blank_d;
      invalid_q     <= invalid_d;
      newDigit_q    <= newDigit_d;
      acceptCount_q <= acceptCount_d;
    end
  end

  // Any input change restarts settling; acceptance happens once per lock-in.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    dp_d          = dp_q;
    valid_d       = valid_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    newDigit_d    = 1'b0;
    acceptCount_d = acceptCount_q;

    if (!inputStable) begin
      state_d = SETTLE;
      cnt_d   = 4'd0;
    end else begin
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (state_q == SETTLE && cnt_q == LOCK_AT) begin
        state_d    = LOCKED;
        newDigit_d = 1'b1;
        dp_d       = s_q[7];
        valid_d    = lutDigit;
        blank_d    = lutBlank;
        invalid_d  = !lutDigit && !lutBlank;
        if (lutDigit) begin
          digit_d = lutValue;
          if (acceptCount_q != COUNT_MAX) begin
            acceptCount_d = acceptCount_q + 8'd1;
          end
        end
      end
    end
  end

  assign digit        = digit_q;
  assign dp           = dp_q;
  assign digit_valid  = valid_q;
  assign blank        = blank_q;
  assign invalid      = invalid_q;
  assign new_digit    = newDigit_q;
  assign accept_count = acceptCount_q;

endmodule : seg_decoder

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: stimulus pushes the expected acceptance and
// the edge it is due on; a monitor pops one entry per new_digit pulse.
module tb_seg_decoder;

  localparam int S = 3;

  typedef struct {
    logic [3:0] digit;
    logic       dp;
    logic       valid;
    logic       blank;
    logic       invalid;
    logic [7:0] count;
    int         due;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [3:0] digit;
  logic       dp;
  logic       digit_valid;
  logic       blank;
  logic       invalid;
  logic       new_digit;
  logic [7:0] accept_count;

  int   edgeCnt = 0;
  int   checks  = 0;
  int   passes  = 0;
  exp_t sbQ[$];

  seg_decoder #(.STABLE_CYCLES(S)) dut (
    .clk_2        (clk_2),
    .reset        (reset),
    .seg_in       (seg_in),
    .digit        (digit),
    .dp           (dp),
    .digit_valid  (digit_valid),
    .blank        (blank),
    .invalid      (invalid),
    .new_digit    (new_digit),
    .accept_count (accept_count)
  );

  always #5 clk_2 = ~clk_2;

  always @(posedge clk_2) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edgeCnt);
  endtask

  task automatic checkReset();
    checkOutput("rst_digit",   32'(digit),        32'd0);
    checkOutput("rst_dp",      32'(dp),           32'd0);
    checkOutput("rst_valid",   32'(digit_valid),  32'd0);
    checkOutput("rst_blank",   32'(blank),        32'd0);
    checkOutput("rst_invalid", 32'(invalid),      32'd0);
    checkOutput("rst_newdig",  32'(new_digit),    32'd0);
    checkOutput("rst_count",   32'(accept_count), 32'd0);
  endtask

  // Drive a pattern for holdCycles edges; if an acceptance is expected, it is
  // due latency edges after the current edge.
  task automatic applyStimulus(input logic [7:0] pat, input int holdCycles, input bit expAcc,
                               input int latency, input logic [3:0] eDigit, input logic eDp,
                               input logic eValid, input logic eBlank, input logic eInvalid,
                               input logic [7:0] eCount);
    exp_t e;
    seg_in = pat;
    if (expAcc) begin
      e.digit   = eDigit;
      e.dp      = eDp;
      e.valid   = eValid;
      e.blank   = eBlank;
      e.invalid = eInvalid;
      e.count   = eCount;
      e.due     = edgeCnt + latency;
      sbQ.push_back(e);
    end
    repeat (holdCycles) @(posedge clk_2);
    #1;
  endtask

  always @(negedge clk_2) begin
    if (new_digit === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_pulse actual=1 required=0 (edge %0d, digit=%0d)", edgeCnt, digit);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("accept_edge", 32'(edgeCnt),      32'(e.due));
        checkOutput("digit",       32'(digit),        32'(e.digit));
        checkOutput("dp",          32'(dp),           32'(e.dp));
        checkOutput("digit_valid", 32'(digit_valid),  32'(e.valid));
        checkOutput("blank",       32'(blank),        32'(e.blank));
        checkOutput("invalid",     32'(invalid),      32'(e.invalid));
        checkOutput("count",       32'(accept_count), 32'(e.count));
      end
    end
  end

  initial begin
    int cnt;
    reset  = 1'b1;
    seg_in = 8'h00;
    repeat (2) @(posedge clk_2);
    #1;
    checkReset();

    reset = 1'b0;
    applyStimulus(8'h5B, 6, 1, S + 1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    applyStimulus(8'h06, 6, 1, S + 1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    applyStimulus(8'h7F, 2, 0, 0,     4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(8'h06, 6, 1, S + 1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    applyStimulus(8'h49, 6, 1, S + 1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    applyStimulus(8'h00, 6, 1, S + 1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    applyStimulus(8'h3F, 6, 1, S + 1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
    applyStimulus(8'hBF, 6, 1, S + 1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    applyStimulus(8'h3F, 1, 0, 0,     4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(8'hBF, 6, 1, S + 1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6);

    // Reset lands on the edge that would have locked 0x6D.
    applyStimulus(8'h6D, S, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    @(posedge clk_2);
    #1;
    checkReset();
    @(posedge clk_2);
    #1;
    reset = 1'b0;
    applyStimulus(8'h00, 6, 1, S, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (cnt < 255) cnt++;
      if (i % 2 == 0)
        applyStimulus(8'h06, S + 1, 1, S + 1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(cnt));
      else
        applyStimulus(8'h5B, S + 1, 1, S + 1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'(cnt));
    end
    applyStimulus(8'h06, 6, 1, S + 1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
    checkOutput("count_hold", 32'(accept_count), 32'd255);

    repeat (4) @(posedge clk_2);
    #1;
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_seg_decoder
